// File: rtl/ioexp_input_filter.sv
// Input conditioning ahead of the I/O-expander register block.
// Each raw pin passes through a two-flop synchronizer and is then
// debounced on a divided sample tick. A one-cycle change strobe and
// mask report which filtered bits moved on a given tick.
module ioexp_input_filter #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      TICK_DIV  = 25000,
    parameter int unsigned      DEB_COUNT = 3,
    parameter logic [WIDTH-1:0] RST_VAL   = '1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iRaw,
    output logic [WIDTH-1:0] oFiltered,
    output logic             oChange,
    output logic [WIDTH-1:0] oChangeMask,
    output logic             oTick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
    localparam logic [PW-1:0] PcntMax = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CntMax  = CW'(DEB_COUNT - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tick;
    logic             tick_q;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] chg_d, chg_mask_q;
    logic             chg_q;
    // cnt == 0 is the STABLE state of a bit, cnt > 0 is PENDING
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    assign tick = (pcnt_q == PcntMax);

    // Prescaler next state: wrap to zero on the tick cycle
    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end

    // Per-bit debounce: only tick cycles can move a counter or a filtered level
    always_comb begin
        filt_d = filt_q;
        chg_d  = '0;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (sync2_q[i] == filt_q[i]) begin
                    // Bounce back to the accepted level cancels the pending change
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    filt_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                    chg_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // All state: synchronizer, prescaler, debounce counters, filtered levels, strobes
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q    <= RST_VAL;
            sync2_q    <= RST_VAL;
            pcnt_q     <= '0;
            tick_q     <= 1'b0;
            filt_q     <= RST_VAL;
            chg_q      <= 1'b0;
            chg_mask_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= iRaw;
            sync2_q    <= sync1_q;
            pcnt_q     <= pcnt_d;
            tick_q     <= tick;
            filt_q     <= filt_d;
            chg_q      <= |chg_d;
            chg_mask_q <= chg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign oFiltered   = filt_q;
    assign oChange     = chg_q;
    assign oChangeMask = chg_mask_q;
    assign oTick       = tick_q;

endmodule

// File: tb/tb_ioexp_input_filter.sv
// Directed bench for ioexp_input_filter with TICK_DIV=4, DEB_COUNT=3.
// Tick updates land on edges where the edge count since reset release
// is a multiple of 4; all sampling is 1 time unit after a rising edge.
module tb_ioexp_input_filter;

    logic        iClk;
    logic        iRst_n;
    logic [15:0] iRaw;
    logic [15:0] oFiltered;
    logic        oChange;
    logic [15:0] oChangeMask;
    logic        oTick;

    int errors = 0;
    int checks = 0;
    int cyc;

    ioexp_input_filter #(
        .WIDTH     (16),
        .TICK_DIV  (4),
        .DEB_COUNT (3),
        .RST_VAL   (16'hFFFF)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iRaw        (iRaw),
        .oFiltered   (oFiltered),
        .oChange     (oChange),
        .oChangeMask (oChangeMask),
        .oTick       (oTick)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Edge count since the last reset release
    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic goto_tick();
        while (cyc % 4 != 0) step();
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        iRaw   = 16'hFFFF;
        step();
        step();
        iRst_n = 1'b1;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        iRaw   = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (oFiltered !== 16'hFFFF) begin
                errors++;
                $display("FAIL reset_filt k=%0d got=%h exp=ffff", k, oFiltered);
            end
            checks++;
            if (oChange !== 1'b0 || oChangeMask !== 16'h0000 || oTick !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobes k=%0d got chg=%b mask=%h tick=%b exp 0/0000/0",
                         k, oChange, oChangeMask, oTick);
            end
        end
        iRaw   = 16'hFFFF;
        iRst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (oTick !== (k == 4)) begin
                errors++;
                $display("FAIL first_tick k=%0d got=%b exp=%b", k, oTick, (k == 4));
            end
        end
    endtask

    task automatic test_glitch();
        goto_tick();
        iRaw[10] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 6) iRaw[10] = 1'b1;
            checks++;
            if (oFiltered !== 16'hFFFF || oChange !== 1'b0) begin
                errors++;
                $display("FAIL glitch_out k=%0d got filt=%h chg=%b exp ffff/0", k, oFiltered, oChange);
            end
            if (k == 8) begin
                checks++;
                if (dut.cnt_q[10] !== 2'd2) begin
                    errors++;
                    $display("FAIL glitch_cnt_pending got=%0d exp=2", dut.cnt_q[10]);
                end
            end
            if (k == 12) begin
                checks++;
                if (dut.cnt_q[10] !== 2'd0) begin
                    errors++;
                    $display("FAIL glitch_cnt_cleared got=%0d exp=0", dut.cnt_q[10]);
                end
            end
        end
    endtask

    task automatic test_clean_change();
        logic [15:0] exp_f, exp_m;
        goto_tick();
        iRaw[3] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_f = (k >= 12) ? 16'hFFF7 : 16'hFFFF;
            exp_m = (k == 12) ? 16'h0008 : 16'h0000;
            checks++;
            if (oFiltered !== exp_f) begin
                errors++;
                $display("FAIL clean_filt k=%0d got=%h exp=%h", k, oFiltered, exp_f);
            end
            checks++;
            if (oChange !== (k == 12) || oChangeMask !== exp_m) begin
                errors++;
                $display("FAIL clean_strobe k=%0d got chg=%b mask=%h exp %b/%h",
                         k, oChange, oChangeMask, (k == 12), exp_m);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_f, exp_m;
        do_reset();
        goto_tick();
        iRaw = 16'h00FF;
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_f = (k >= 12) ? 16'h00FF : 16'hFFFF;
            exp_m = (k == 12) ? 16'hFF00 : 16'h0000;
            checks++;
            if (oFiltered !== exp_f) begin
                errors++;
                $display("FAIL simul_filt k=%0d got=%h exp=%h", k, oFiltered, exp_f);
            end
            checks++;
            if (oChange !== (k == 12) || oChangeMask !== exp_m) begin
                errors++;
                $display("FAIL simul_strobe k=%0d got chg=%b mask=%h exp %b/%h",
                         k, oChange, oChangeMask, (k == 12), exp_m);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] exp_f, exp_m;
        goto_tick();
        iRaw[0] = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 9)  iRaw[0] = 1'b1;
            if (k == 13) iRaw[0] = 1'b0;
            exp_f = (k >= 24) ? 16'h00FE : 16'h00FF;
            exp_m = (k == 24) ? 16'h0001 : 16'h0000;
            checks++;
            if (oFiltered !== exp_f) begin
                errors++;
                $display("FAIL bounce_filt k=%0d got=%h exp=%h", k, oFiltered, exp_f);
            end
            checks++;
            if (oChange !== (k == 24) || oChangeMask !== exp_m) begin
                errors++;
                $display("FAIL bounce_strobe k=%0d got chg=%b mask=%h exp %b/%h",
                         k, oChange, oChangeMask, (k == 24), exp_m);
            end
            if (k == 8 || k == 12) begin
                checks++;
                if (dut.cnt_q[0] !== ((k == 8) ? 2'd2 : 2'd0)) begin
                    errors++;
                    $display("FAIL bounce_cnt k=%0d got=%0d exp=%0d", k, dut.cnt_q[0],
                             (k == 8) ? 2 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [15:0] exp_f;
        goto_tick();
        iRaw = 16'h00DE;
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        checks++;
        if (dut.cnt_q[5] !== 2'd2) begin
            errors++;
            $display("FAIL mid_cnt_before got=%0d exp=2", dut.cnt_q[5]);
        end
        iRst_n = 1'b0;
        #1;
        checks++;
        if (oFiltered !== 16'hFFFF || oChange !== 1'b0 || dut.cnt_q[5] !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_reset got filt=%h chg=%b cnt5=%0d exp ffff/0/0",
                     oFiltered, oChange, dut.cnt_q[5]);
        end
        iRaw = 16'hFFDF;
        step();
        step();
        iRst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_f = (k >= 12) ? 16'hFFDF : 16'hFFFF;
            checks++;
            if (oFiltered !== exp_f || oChange !== (k == 12)) begin
                errors++;
                $display("FAIL mid_after_release k=%0d got filt=%h chg=%b exp %h/%b",
                         k, oFiltered, oChange, exp_f, (k == 12));
            end
        end
    endtask

    initial begin
        iRst_n = 1'b0;
        iRaw   = 16'h0000;
        test_reset();
        test_glitch();
        test_clean_change();
        test_simultaneous();
        test_bounce();
        test_reset_mid_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
